// File: rtl/count_snapshot_if.sv
// ---------------------------------------------------------------------------
// count_snapshot_if
//
// Purpose:
//   Snapshot read-out channel of count_snapshot. The producer presents the
//   oldest stored snapshot and the consumer accepts it with a ready strobe.
//
// Parameters:
//   WRAP_W      width of the wrap-event counter (snapshot word is WRAP_W+4)
//
// Signals:
//   SNAP_DATA   head snapshot {wrap count, Q}      producer -> consumer
//   SNAP_VALID  snapshot FIFO holds at least one   producer -> consumer
//   SNAP_READY  consumer accepts the head entry    consumer -> producer
//
// Modports:
//   master      snapshot producer (count_snapshot)
//   slave       snapshot consumer
// ---------------------------------------------------------------------------
interface count_snapshot_if #(
    parameter int WRAP_W = 8
) ();

    logic [WRAP_W+3:0] SNAP_DATA;
    logic              SNAP_VALID;
    logic              SNAP_READY;

    modport master (
        output SNAP_DATA,
        output SNAP_VALID,
        input  SNAP_READY
    );

    modport slave (
        input  SNAP_DATA,
        input  SNAP_VALID,
        output SNAP_READY
    );

endinterface

// File: rtl/count_snapshot.sv
// ---------------------------------------------------------------------------
// count_snapshot
//
// Purpose:
//   Extends an upstream 4-bit binary counter with a WRAP_W-bit count of its
//   ripple-carry (wrap) events, and captures {wrap count, Q} snapshots on
//   request into a 2-entry FIFO that a consumer drains through a
//   valid/ready channel. Sticky flags record counter overflow and captures
//   lost to a full FIFO.
//
// Parameters:
//   WRAP_W     width of the wrap-event counter, legal range 2..16
//
// Configuration macro:
//   COUNT_SNAPSHOT_SAT_EN  when defined, WRAP_CNT saturates at its maximum
//                          instead of wrapping to 0 (OVF is set either way)
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   CLR        synchronous active-high reset, overrides every other input
//   Q_IN       upstream counter value
//   RCO_IN     upstream ripple carry (counter advances 15->0 at this edge)
//   CAP_REQ    capture request, sampled every edge
//   STAT_CLR   clears the sticky OVF / CAP_DROP flags
//   WRAP_CNT   live wrap-event count
//   OVF        sticky: WRAP_CNT passed its maximum value
//   CAP_DROP   sticky: a capture was discarded because the FIFO was full
//   snap       snapshot channel (master side): SNAP_DATA, SNAP_VALID out,
//              SNAP_READY in
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module count_snapshot #(
    parameter int WRAP_W = 8
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic [3:0]        Q_IN,
    input  logic              RCO_IN,
    input  logic              CAP_REQ,
    input  logic              STAT_CLR,
    output logic [WRAP_W-1:0] WRAP_CNT,
    output logic              OVF,
    output logic              CAP_DROP,
    count_snapshot_if.master  snap
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [WRAP_W-1:0] CNT_MAX = '1;
    localparam logic [WRAP_W-1:0] CNT_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [WRAP_W+3:0] head;
    logic [WRAP_W+3:0] tail;

    logic              push;
    logic              pop;
    logic [WRAP_W+3:0] push_word;
    logic              wrap_event;
    logic              drop_event;

    // The captured word uses the pre-edge count, so a same-edge RCO
    // increment is not part of the snapshot.
    assign push       = CAP_REQ;
    assign pop        = (state != ST_EMPTY) && snap.SNAP_READY;
    assign push_word  = {WRAP_CNT, Q_IN};
    assign wrap_event = RCO_IN && (WRAP_CNT == CNT_MAX);
    assign drop_event = push && (state == ST_FULL) && !pop;

    assign snap.SNAP_DATA  = head;
    assign snap.SNAP_VALID = (state != ST_EMPTY);

    // Two-entry snapshot FIFO: head is always the oldest entry and drives
    // SNAP_DATA directly, tail only holds the second entry in FULL.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= ST_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        head  <= push_word;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        // Old head leaves, new word becomes the only entry.
                        head <= push_word;
                    end else if (push) begin
                        tail  <= push_word;
                        state <= ST_FULL;
                    end else if (pop) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head <= tail;
                        if (push) begin
                            tail <= push_word;
                        end else begin
                            state <= ST_ONE;
                        end
                    end
                    // Push without pop is dropped; contents stay as they are.
                end
                default: begin
                    state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Wrap-event counter and sticky status flags. A set event on the same
    // edge as STAT_CLR wins, so no event is ever lost to a clear.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            WRAP_CNT <= '0;
            OVF      <= 1'b0;
            CAP_DROP <= 1'b0;
        end else begin
            if (RCO_IN) begin
`ifdef COUNT_SNAPSHOT_SAT_EN
                if (WRAP_CNT != CNT_MAX) begin
                    WRAP_CNT <= WRAP_CNT + CNT_ONE;
                end
`else
                WRAP_CNT <= WRAP_CNT + CNT_ONE;
`endif
            end

            if (wrap_event) begin
                OVF <= 1'b1;
            end else if (STAT_CLR) begin
                OVF <= 1'b0;
            end

            if (drop_event) begin
                CAP_DROP <= 1'b1;
            end else if (STAT_CLR) begin
                CAP_DROP <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_snapshot.sv
// ---------------------------------------------------------------------------
// tb_count_snapshot
//
// Purpose:
//   Self-checking bench for count_snapshot with WRAP_W = 8. A behavioural
//   model (integer counter, word queue, sticky bits) predicts every output
//   after each edge; directed scenarios are followed by random traffic.
//   Honours COUNT_SNAPSHOT_SAT_EN if the design is built with it.
// ---------------------------------------------------------------------------
module tb_count_snapshot;

    localparam int WRAP_W = 8;
    localparam int DW     = WRAP_W + 4;
    localparam int CNT_MAX_I = (1 << WRAP_W) - 1;

    logic              CLK = 1'b0;
    logic              CLR = 1'b0;
    logic [3:0]        Q_IN = 4'd0;
    logic              RCO_IN = 1'b0;
    logic              CAP_REQ = 1'b0;
    logic              STAT_CLR = 1'b0;
    logic [WRAP_W-1:0] WRAP_CNT;
    logic              OVF;
    logic              CAP_DROP;

    count_snapshot_if #(.WRAP_W(WRAP_W)) sif ();

    count_snapshot #(.WRAP_W(WRAP_W)) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .Q_IN     (Q_IN),
        .RCO_IN   (RCO_IN),
        .CAP_REQ  (CAP_REQ),
        .STAT_CLR (STAT_CLR),
        .WRAP_CNT (WRAP_CNT),
        .OVF      (OVF),
        .CAP_DROP (CAP_DROP),
        .snap     (sif)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            mCnt;
    bit            mOvf;
    bit            mDrop;
    logic [DW-1:0] mQueue[$];
    bit            mDataKnown;

    // Compare one observed value against the model's expectation.
    task automatic checkValue(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Check all outputs against the reference model.
    task automatic checkOutput(input string tag);
        logic [DW-1:0] expData;
        checkValue({tag, ".wrap_cnt"}, DW'(WRAP_CNT), DW'(mCnt));
        checkValue({tag, ".ovf"}, DW'(OVF), DW'(mOvf));
        checkValue({tag, ".cap_drop"}, DW'(CAP_DROP), DW'(mDrop));
        checkValue({tag, ".snap_valid"}, DW'(sif.SNAP_VALID), DW'(mQueue.size() > 0));
        if (mQueue.size() > 0 || mDataKnown) begin
            expData = (mQueue.size() > 0) ? mQueue[0] : '0;
            checkValue({tag, ".snap_data"}, sif.SNAP_DATA, expData);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check.
    task automatic applyStimulus(input string tag, input bit cap, input bit rdy,
                                 input bit rco, input bit stat, input bit clr,
                                 input logic [3:0] q);
        bit            popped;
        bit            ovfSet;
        bit            dropSet;
        logic [DW-1:0] word;
        @(negedge CLK);
        CAP_REQ        = cap;
        sif.SNAP_READY = rdy;
        RCO_IN         = rco;
        STAT_CLR       = stat;
        CLR            = clr;
        Q_IN           = q;
        @(posedge CLK);
        if (clr) begin
            mQueue.delete();
            mCnt       = 0;
            mOvf       = 0;
            mDrop      = 0;
            mDataKnown = 1;
        end else begin
            ovfSet  = 0;
            dropSet = 0;
            word    = {8'(mCnt), q};
            popped  = (mQueue.size() > 0) && rdy;
            if (popped) begin
                void'(mQueue.pop_front());
                if (mQueue.size() == 0) mDataKnown = 0;
            end
            if (cap) begin
                if (mQueue.size() < 2) mQueue.push_back(word);
                else dropSet = 1;
            end
            if (rco) begin
                if (mCnt == CNT_MAX_I) begin
                    ovfSet = 1;
`ifdef COUNT_SNAPSHOT_SAT_EN
                    mCnt = CNT_MAX_I;
`else
                    mCnt = 0;
`endif
                end else begin
                    mCnt = mCnt + 1;
                end
            end
            mOvf  = (stat ? 1'b0 : mOvf) | ovfSet;
            mDrop = (stat ? 1'b0 : mDrop) | dropSet;
        end
        #1;
        checkOutput(tag);
    endtask

    initial begin
        sif.SNAP_READY = 1'b0;
        mCnt = 0; mOvf = 0; mDrop = 0; mDataKnown = 0;

        $display("[TB] reset with capture and RCO asserted");
        applyStimulus("rst0", 1, 0, 1, 0, 1, 4'd5);
        applyStimulus("pre1", 1, 0, 1, 0, 0, 4'd7);
        applyStimulus("pre2", 1, 0, 1, 0, 0, 4'd8);
        applyStimulus("rst1", 1, 1, 1, 0, 1, 4'd6);
        checkValue("rst.data_zero", sif.SNAP_DATA, '0);
        checkValue("rst.valid_zero", DW'(sif.SNAP_VALID), '0);

        $display("[TB] capture right after reset, then hold with count 3");
        applyStimulus("firstcap", 1, 0, 1, 0, 0, 4'd2);
        applyStimulus("clr2", 0, 0, 0, 0, 1, 4'd0);
        for (int i = 0; i < 3; i++) applyStimulus("rco3", 0, 0, 1, 0, 0, 4'd0);
        applyStimulus("cap39", 1, 0, 0, 0, 0, 4'd9);
        for (int i = 0; i < 10; i++) begin
            applyStimulus("hold39", 0, 0, 0, 0, 0, 4'(i));
            checkValue("hold39.const", sif.SNAP_DATA, 12'h039);
        end

        $display("[TB] three captures into two-entry FIFO, then drain");
        applyStimulus("clr3", 0, 0, 0, 0, 1, 4'd0);
        applyStimulus("c1", 1, 0, 0, 0, 0, 4'd1);
        applyStimulus("c2", 1, 0, 0, 0, 0, 4'd2);
        applyStimulus("c3", 1, 0, 0, 0, 0, 4'd3);
        checkValue("c3.drop", DW'(CAP_DROP), DW'(1));
        checkValue("c3.head", sif.SNAP_DATA, 12'h001);
        applyStimulus("pop1", 0, 1, 0, 0, 0, 4'd0);
        checkValue("pop1.head", sif.SNAP_DATA, 12'h002);
        applyStimulus("pop2", 0, 1, 0, 0, 0, 4'd0);
        applyStimulus("pop3", 0, 1, 0, 0, 0, 4'd0);

        $display("[TB] push and pop on the same edge");
        applyStimulus("clr4", 0, 0, 0, 0, 1, 4'd0);
        applyStimulus("f1", 1, 0, 0, 0, 0, 4'd4);
        applyStimulus("f2", 1, 0, 0, 0, 0, 4'd5);
        applyStimulus("fpp", 1, 1, 0, 0, 0, 4'd6);
        checkValue("fpp.nodrop", DW'(CAP_DROP), '0);
        applyStimulus("fpop1", 0, 1, 0, 0, 0, 4'd0);
        checkValue("fpop1.head", sif.SNAP_DATA, 12'h006);
        applyStimulus("onepp", 1, 1, 0, 0, 0, 4'd10);
        applyStimulus("fpop2", 0, 1, 0, 0, 0, 4'd0);

        $display("[TB] 256 RCO pulses");
        applyStimulus("clr5", 0, 0, 0, 0, 1, 4'd0);
        for (int i = 0; i < 256; i++) applyStimulus("rco256", 0, 0, 1, 0, 0, 4'd0);
`ifdef COUNT_SNAPSHOT_SAT_EN
        checkValue("rco256.const", DW'(WRAP_CNT), DW'(255));
`else
        checkValue("rco256.const", DW'(WRAP_CNT), DW'(0));
`endif
        checkValue("rco256.ovf", DW'(OVF), DW'(1));

        $display("[TB] status clear behaviour");
        applyStimulus("statclr", 0, 0, 0, 1, 0, 4'd0);
        checkValue("statclr.ovf", DW'(OVF), '0);
        applyStimulus("s1", 1, 0, 0, 0, 0, 4'd1);
        applyStimulus("s2", 1, 0, 0, 0, 0, 4'd2);
        applyStimulus("sdrop", 1, 0, 0, 1, 0, 4'd3);
        checkValue("sdrop.sticky", DW'(CAP_DROP), DW'(1));
        applyStimulus("sclr2", 0, 0, 0, 1, 0, 4'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 1500; i++) begin
            applyStimulus("rand",
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 2) != 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 63) == 0),
                          4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_snapshot.md
COUNT_SNAPSHOT -- requirements
Module: count_snapshot

Interface
REQ-001 Parameter WRAP_W, default 8, width of the wrap (RCO event) counter; legal range 2..16.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 CLR  input  1  reset, synchronous, active-high.
REQ-004 Q_IN  input  4  count value from the upstream 4-bit binary counter.
REQ-005 RCO_IN  input  1  ripple carry from the upstream counter; high means the counter advances 15->0 at this edge.
REQ-006 CAP_REQ  input  1  capture request, sampled each edge.
REQ-007 SNAP_READY  input  1  consumer accepts the head snapshot.
REQ-008 STAT_CLR  input  1  clears sticky status flags.
REQ-009 SNAP_DATA  output  WRAP_W+4  head snapshot {wrap count, Q}.
REQ-010 SNAP_VALID  output  1  FIFO non-empty.
REQ-011 WRAP_CNT  output  WRAP_W  live wrap event count.
REQ-012 OVF  output  1  sticky: WRAP_CNT passed its maximum value.
REQ-013 CAP_DROP  output  1  sticky: a capture was lost because the FIFO was full.

Function
REQ-014 WRAP_CNT shall increment by 1 on every edge where RCO_IN=1; otherwise it shall hold.
REQ-015 When WRAP_CNT = 2^WRAP_W-1 and RCO_IN=1, WRAP_CNT shall wrap to 0 and OVF shall be set at the same edge.
REQ-016 On an edge with CAP_REQ=1, the word {WRAP_CNT, Q_IN} shall be pushed, using pre-edge values (the same-edge RCO increment is not included).
REQ-017 Snapshot storage shall be a 2-entry FIFO with states EMPTY, ONE and FULL; SNAP_DATA shall present the oldest entry.
REQ-018 SNAP_VALID shall be 1 in states ONE and FULL; push-to-SNAP_VALID latency is one edge when the FIFO is EMPTY.
REQ-019 A pop shall occur on an edge with SNAP_VALID=1 and SNAP_READY=1; SNAP_READY while EMPTY shall have no effect.
REQ-020 Transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE with the new entry at the head; FULL+pop->ONE; FULL+push+pop->FULL with the new entry at the tail.
REQ-021 A push in FULL without a same-edge pop shall be discarded and CAP_DROP set; FIFO contents shall remain unchanged.
REQ-022 SNAP_DATA shall hold stable while SNAP_VALID=1 and no pop occurs.
REQ-023 STAT_CLR=1 shall clear OVF and CAP_DROP at the edge; a same-edge set event wins, and the flag stays 1.
REQ-024 No combinational path shall run from any input to any output.

Reset
REQ-025 CLR=1 at an edge shall force WRAP_CNT=0, OVF=0, CAP_DROP=0, FIFO=EMPTY, SNAP_VALID=0 and SNAP_DATA=0, overriding all other inputs.
REQ-026 CLR asserted during a capture or pop shall discard that operation and all stored entries.
REQ-027 The first capture after CLR deasserts shall be honoured on that same edge.

Configuration
REQ-028 Macro COUNT_SNAPSHOT_SAT_EN: when defined, WRAP_CNT shall saturate at 2^WRAP_W-1 (RCO_IN=1 holds it there and sets OVF); when undefined, REQ-015 wrap behaviour applies.

Verification
REQ-029 CLR pulse with CAP_REQ=1 and RCO_IN=1 -> next cycle: all outputs 0 and SNAP_VALID=0.
REQ-030 Q_IN=9, WRAP_CNT=3, CAP_REQ one cycle, SNAP_READY=0 -> SNAP_VALID=1 and SNAP_DATA=0x039 held for 10 cycles.
REQ-031 Three captures (Q=1,2,3) with SNAP_READY=0, then SNAP_READY=1 -> pops yield Q=1 then Q=2, then SNAP_VALID=0; CAP_DROP=1.
REQ-032 FULL with CAP_REQ=1 and SNAP_READY=1 on the same edge -> no drop; remaining order is second entry then new entry.
REQ-033 256 RCO_IN pulses, WRAP_W=8 -> without the macro WRAP_CNT=0 and OVF=1; with COUNT_SNAPSHOT_SAT_EN WRAP_CNT=255 and OVF=1.
REQ-034 OVF=1, then STAT_CLR=1 with no overflow event -> OVF=0; STAT_CLR=1 on the same edge as a drop -> CAP_DROP stays 1.
